// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: frames UART bytes (SYNC, OP, LEN, payload, CHK) into cipher-core loads and start pulses
module uart_cmd_ctrl #(
    parameter int         CLK_FREQ      = 30_000_000,
    parameter int         BAUD          = 9600,
    parameter int         MAX_LEN       = 16,
    parameter int         TIMEOUT_BYTES = 4,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_done,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_byte,
    input  logic                       core_busy,
    output logic                       wr_en,
    output logic [$clog2(MAX_LEN)-1:0] wr_addr,
    output logic [7:0]                 wr_data,
    output logic                       cmd_start,
    output logic [7:0]                 cmd_op,
    output logic [$clog2(MAX_LEN):0]   cmd_len,
    output logic                       err,
    output logic [1:0]                 err_code
);
    localparam int AW     = $clog2(MAX_LEN);
    localparam int TO_CYC = TIMEOUT_BYTES * 11 * (CLK_FREQ / BAUD);
    localparam int TW     = $clog2(TO_CYC);

    typedef enum logic [2:0] {HUNT, OP, LEN, PAY, CHK, ISSUE} state_t;

    state_t        state, state_nx;
    logic [7:0]    op, chk;
    logic [AW:0]   len;
    logic [AW-1:0] idx;
    logic [TW-1:0] to_cnt;
    logic          in_frame, len_ok, to_exp, wr_nx, start_nx, err_nx;
    logic [1:0]    code_nx;

    assign in_frame = state inside {OP, LEN, PAY, CHK};
    assign len_ok   = rx_byte != 8'd0 && int'(rx_byte) <= MAX_LEN;
    // Fires in the cycle whose increment would reach TO_CYC-1, so a byte arriving then still wins
    assign to_exp   = in_frame && to_cnt == TW'(TO_CYC - 2);

    always_comb begin
        state_nx = state;
        wr_nx    = 1'b0;
        start_nx = 1'b0;
        err_nx   = 1'b0;
        code_nx  = err_code;
        if (state == HUNT) begin
            if (rx_done && rx_valid && rx_byte == SYNC_BYTE)
                state_nx = OP;
        end else if (state == ISSUE) begin
            start_nx = !core_busy;
            state_nx = core_busy ? ISSUE : HUNT;
        end else if (rx_done && !rx_valid) begin
            state_nx = HUNT;
            err_nx   = 1'b1;
            code_nx  = 2'd2;
        end else if (rx_done) begin
            wr_nx = state == PAY;
            case (state)
                OP:      state_nx = LEN;
                LEN:     state_nx = len_ok ? PAY : HUNT;
                PAY:     state_nx = idx == AW'(len - 1'b1) ? CHK : PAY;
                CHK:     state_nx = rx_byte == chk ? ISSUE : HUNT;
                default: state_nx = HUNT;
            endcase
            err_nx  = (state == LEN && !len_ok) || (state == CHK && rx_byte != chk);
            code_nx = err_nx ? (state == LEN ? 2'd0 : 2'd1) : err_code;
        end else if (to_exp) begin
            state_nx = HUNT;
            err_nx   = 1'b1;
            code_nx  = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            op        <= '0;
            chk       <= '0;
            len       <= '0;
            idx       <= '0;
            to_cnt    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cmd_start <= 1'b0;
            cmd_op    <= '0;
            cmd_len   <= '0;
            err       <= 1'b0;
            err_code  <= '0;
        end else begin
            state     <= state_nx;
            wr_en     <= wr_nx;
            cmd_start <= start_nx;
            err       <= err_nx;
            err_code  <= code_nx;
            to_cnt    <= (rx_done || !in_frame) ? '0 : to_cnt + 1'b1;
            if (start_nx) begin
                cmd_op  <= op;
                cmd_len <= len;
            end
            if (rx_done && state == OP) begin
                op  <= rx_byte;
                chk <= rx_byte;
            end
            if (rx_done && state == LEN) begin
                len <= rx_byte[AW:0];
                chk <= chk ^ rx_byte;
                idx <= '0;
            end
            if (wr_nx) begin
                wr_addr <= idx;
                wr_data <= rx_byte;
                chk     <= chk ^ rx_byte;
                idx     <= idx + 1'b1;
            end
        end
    end
endmodule
